// File: rtl/hamming_secded_dec.sv
// Pipelined SECDED Hamming decoder: syndrome/parity stage, then correction and classification.
// Carries saturating counters of corrected and uncorrectable words delivered downstream.
module hamming_secded_dec #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned PAR_W = (DATA_W <= 4)  ? 3 :
                                    (DATA_W <= 11) ? 4 :
                                    (DATA_W <= 26) ? 5 : 6,
    localparam int unsigned CODE_W = DATA_W + PAR_W
) (
    input  logic              ip_clk,
    input  logic              ip_rst_n,
    input  logic [CODE_W-1:0] ip_code,
    input  logic              ip_parity,
    input  logic              ip_valid,
    output logic              op_ready,
    output logic [DATA_W-1:0] op_data,
    output logic [PAR_W-1:0]  op_syndrome,
    output logic              op_single_err,
    output logic              op_double_err,
    output logic              op_valid,
    input  logic              ip_ready,
    input  logic              ip_cnt_clr,
    output logic [CNT_W-1:0]  op_corr_cnt,
    output logic [CNT_W-1:0]  op_uncorr_cnt
);

    // Hamming position (1-based) of data bit idx: the idx-th non-power-of-two position.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned pos;
        int unsigned cnt;
        pos = 0;
        cnt = 0;
        for (int unsigned p = 1; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx && pos == 0) pos = p;
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    logic              s1_valid_q;
    logic [CODE_W-1:0] s1_code_q;
    logic [PAR_W-1:0]  s1_syn_q;
    logic              s1_par_q;

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [PAR_W-1:0]  syn_q;
    logic              single_q;
    logic              double_q;

    logic [CNT_W-1:0]  corr_q, corr_d;
    logic [CNT_W-1:0]  uncorr_q, uncorr_d;

    logic              s2_adv;
    logic              s1_adv;
    logic              in_xfer;
    logic              out_xfer;

    logic [PAR_W-1:0]  syn_in;
    logic              par_in;
    logic [CODE_W-1:0] flip;
    logic [CODE_W-1:0] fixed_code;
    logic [DATA_W-1:0] dec_data;
    logic              syn_nz;
    logic              dec_single;
    logic              dec_double;

    assign s2_adv   = !valid_q || ip_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign op_ready = s1_adv;
    assign in_xfer  = ip_valid && op_ready;
    assign out_xfer = valid_q && ip_ready;

    // Stage 1 combinational: syndrome is the XOR of the positions of all set bits.
    always_comb begin
        syn_in = '0;
        for (int k = 0; k < CODE_W; k++) begin
            if (ip_code[k]) syn_in = syn_in ^ PAR_W'(k + 1);
        end
    end

    assign par_in = (^ip_code) ^ ip_parity;

    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_xfer;
            if (in_xfer) begin
                s1_code_q <= ip_code;
                s1_syn_q  <= syn_in;
                s1_par_q  <= par_in;
            end
        end
    end

    // One-hot decode of the syndrome; all zero when S is 0 or points beyond the codeword.
    always_comb begin
        flip = '0;
        for (int k = 0; k < CODE_W; k++) begin
            flip[k] = (s1_syn_q == PAR_W'(k + 1));
        end
    end

    assign syn_nz     = |s1_syn_q;
    assign dec_single = s1_par_q && (!syn_nz || (|flip));
    assign dec_double = syn_nz && !(s1_par_q && (|flip));
    // Only an odd overall parity licenses a correction; double errors pass the raw code.
    assign fixed_code = s1_par_q ? (s1_code_q ^ flip) : s1_code_q;

    for (genvar j = 0; j < DATA_W; j++) begin : g_extract
        localparam int unsigned Pos = data_pos(j);
        assign dec_data[j] = fixed_code[Pos-1];
    end

    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            syn_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
        end else if (s2_adv) begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q   <= dec_data;
                syn_q    <= s1_syn_q;
                single_q <= dec_single;
                double_q <= dec_double;
            end
        end
    end

    // Clear takes priority over an increment in the same cycle.
    always_comb begin
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        if (ip_cnt_clr) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else if (out_xfer) begin
            if (single_q && (corr_q != '1)) corr_d = corr_q + CNT_W'(1);
            if (double_q && (uncorr_q != '1)) uncorr_d = uncorr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
        end
    end

    assign op_valid      = valid_q;
    assign op_data       = data_q;
    assign op_syndrome   = syn_q;
    assign op_single_err = single_q;
    assign op_double_err = double_q;
    assign op_corr_cnt   = corr_q;
    assign op_uncorr_cnt = uncorr_q;

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Scoreboard bench for hamming_secded_dec: a DATA_W=4 instance and a DATA_W=8, CNT_W=2 instance.
// Stimulus pushes expected words into per-instance queues; negedge monitors pop and compare.
module tb_hamming_secded_dec;

    typedef struct {
        logic [7:0] data;
        logic [3:0] syn;
        logic       se;
        logic       de;
        int         t;
        bit         chk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q4[$];
    exp_t q8[$];

    // Instance with DATA_W=4
    logic        rst4_n = 1'b0;
    logic [6:0]  code4  = '0;
    logic        par4   = 1'b0;
    logic        val4   = 1'b0;
    logic        rdy4;
    logic [3:0]  data4;
    logic [2:0]  syn4;
    logic        se4, de4, ov4;
    logic        ir4    = 1'b1;
    logic        clr4   = 1'b0;
    logic [15:0] corr4, unc4;

    // Instance with DATA_W=8, CNT_W=2
    logic        rst8_n = 1'b0;
    logic [11:0] code8  = '0;
    logic        par8   = 1'b0;
    logic        val8   = 1'b0;
    logic        rdy8;
    logic [7:0]  data8;
    logic [3:0]  syn8;
    logic        se8, de8, ov8;
    logic        ir8    = 1'b1;
    logic        clr8   = 1'b0;
    logic [1:0]  corr8, unc8;
    bit          rand_rdy = 1'b0;

    hamming_secded_dec #(.DATA_W(4), .CNT_W(16)) u_dec4 (
        .ip_clk(clk), .ip_rst_n(rst4_n), .ip_code(code4), .ip_parity(par4), .ip_valid(val4),
        .op_ready(rdy4), .op_data(data4), .op_syndrome(syn4), .op_single_err(se4),
        .op_double_err(de4), .op_valid(ov4), .ip_ready(ir4), .ip_cnt_clr(clr4),
        .op_corr_cnt(corr4), .op_uncorr_cnt(unc4)
    );

    hamming_secded_dec #(.DATA_W(8), .CNT_W(2)) u_dec8 (
        .ip_clk(clk), .ip_rst_n(rst8_n), .ip_code(code8), .ip_parity(par8), .ip_valid(val8),
        .op_ready(rdy8), .op_data(data8), .op_syndrome(syn8), .op_single_err(se8),
        .op_double_err(de8), .op_valid(ov8), .ip_ready(ir8), .ip_cnt_clr(clr8),
        .op_corr_cnt(corr8), .op_uncorr_cnt(unc8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Reference encoder: data in non-power-of-two positions, parity bits zero the syndrome.
    function automatic logic [63:0] enc(input int dw, input int pw, input logic [63:0] d,
                                        output logic par);
        logic [63:0] c;
        logic [7:0]  s;
        int          j;
        c = '0;
        s = '0;
        j = 0;
        for (int p = 1; p <= dw + pw; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                if (d[j]) s = s ^ 8'(p);
                j++;
            end
        end
        for (int i = 0; i < pw; i++) c[(1 << i) - 1] = s[i];
        par = ^c;
        return c;
    endfunction

    function automatic exp_t mk(input logic [7:0] d, input logic [3:0] s, input logic se,
                                input logic de, input bit chk);
        exp_t e;
        e.data = d;
        e.syn  = s;
        e.se   = se;
        e.de   = de;
        e.t    = 0;
        e.chk  = chk;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send4(input logic [6:0] c, input logic p, input exp_t e);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        code4 = c;
        par4 = p;
        val4 = 1'b1;
        e.t = cyc;
        q4.push_back(e);
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = rdy4;
            @(posedge clk);
            #1;
            n++;
        end
        val4 = 1'b0;
        if (!acc) fail("u4 input handshake timeout");
    endtask

    task automatic send8(input logic [11:0] c, input logic p, input exp_t e);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        code8 = c;
        par8 = p;
        val8 = 1'b1;
        e.t = cyc;
        q8.push_back(e);
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = rdy8;
            @(posedge clk);
            #1;
            n++;
        end
        val8 = 1'b0;
        if (!acc) fail("u8 input handshake timeout");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (q4.size() != 0 || q8.size() != 0) fail("drain timeout, words missing");
        @(posedge clk);
        #1;
    endtask

    initial begin : mon4
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst4_n && ov4 && ir4) begin
                if (q4.size() == 0) begin
                    fail("u4 unexpected output word");
                end else begin
                    e = q4.pop_front();
                    check("u4 data", data4, e.data);
                    check("u4 syndrome", syn4, e.syn);
                    check("u4 single_err", se4, e.se);
                    check("u4 double_err", de4, e.de);
                    if (e.chk) check("u4 latency", cyc, e.t + 2);
                end
            end
        end
    end

    initial begin : mon8
        exp_t       e;
        int         occ;
        bit         prev_stall;
        logic [7:0] prev_data;
        occ = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst8_n) begin
                occ = 0;
                prev_stall = 1'b0;
            end else begin
                check("u8 op_ready", rdy8, (occ == 2 && !ir8) ? 1'b0 : 1'b1);
                if (prev_stall) begin
                    check("u8 hold valid", ov8, 1'b1);
                    check("u8 hold data", data8, prev_data);
                end
                if (ov8 && ir8) begin
                    if (q8.size() == 0) begin
                        fail("u8 unexpected output word");
                    end else begin
                        e = q8.pop_front();
                        check("u8 data", data8, e.data);
                        check("u8 syndrome", syn8, e.syn);
                        check("u8 single_err", se8, e.se);
                        check("u8 double_err", de8, e.de);
                    end
                    occ--;
                end
                if (val8 && rdy8) occ++;
                prev_stall = ov8 && !ir8;
                prev_data = data8;
            end
        end
    end

    initial begin : rdy_drv
        forever begin
            @(posedge clk);
            #1;
            ir8 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [63:0] c;
        logic        p;
        logic [7:0]  d;
        int          n;

        #12;
        check("reset u4 op_valid", ov4, 1'b0);
        check("reset u4 op_ready", rdy4, 1'b1);
        check("reset u4 op_data", data4, 4'h0);
        check("reset u4 counters", {corr4, unc4}, 32'h0);
        check("reset u8 op_valid", ov8, 1'b0);
        check("reset u8 op_ready", rdy8, 1'b1);
        check("reset u8 counters", {corr8, unc8}, 4'h0);
        rst4_n = 1'b1;
        rst8_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean sweep with continuous ready: checks data, flags and 2-cycle latency.
        for (int i = 0; i < 16; i++) begin
            c = enc(4, 3, 64'(i), p);
            send4(c[6:0], p, mk(8'(i), 4'h0, 1'b0, 1'b0, 1'b1));
        end
        send4(7'b1010101, 1'b0, mk(8'hB, 4'h0, 1'b0, 1'b0, 1'b1));
        send4(7'b0101101, 1'b0, mk(8'h5, 4'h0, 1'b0, 1'b0, 1'b1));
        drain();
        check("u4 counters after clean sweep", {corr4, unc4}, 32'h0);

        send4(7'b1000101, 1'b0, mk(8'hB, 4'h5, 1'b1, 1'b0, 1'b0));
        drain();
        check("u4 corr_cnt after single", corr4, 16'd1);

        send4(7'b1010110, 1'b0, mk(8'hB, 4'h3, 1'b0, 1'b1, 1'b0));
        drain();
        check("u4 uncorr_cnt after double", unc4, 16'd1);
        check("u4 corr_cnt unchanged", corr4, 16'd1);

        // DATA_W=8: 0xA5 codeword is 0xA27 with parity 0.
        send8(12'h227, 1'b0, mk(8'hA5, 4'd12, 1'b1, 1'b0, 1'b0));
        send8(12'h000, 1'b1, mk(8'h00, 4'd0, 1'b1, 1'b0, 1'b0));
        drain();
        check("u8 corr_cnt after two singles", corr8, 2'd2);

        // Backpressure burst with mixed clean, single and double errors.
        rand_rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            d = 8'($urandom_range(0, 255));
            c = enc(8, 4, 64'(d), p);
            if (i % 4 == 0) begin
                c[i % 12] = ~c[i % 12];
                send8(c[11:0], p, mk(d, 4'((i % 12) + 1), 1'b1, 1'b0, 1'b0));
            end else if (i % 8 == 3) begin
                c[0] = ~c[0];
                c[5] = ~c[5];
                send8(c[11:0], p, mk(d ^ 8'h04, 4'd7, 1'b0, 1'b1, 1'b0));
            end else begin
                send8(c[11:0], p, mk(d, 4'd0, 1'b0, 1'b0, 1'b0));
            end
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Saturation of a 2-bit counter.
        clr8 = 1'b1;
        @(posedge clk);
        #1;
        clr8 = 1'b0;
        check("u8 counters after clear", {corr8, unc8}, 4'h0);
        for (int i = 0; i < 5; i++) send8(12'h227, 1'b0, mk(8'hA5, 4'd12, 1'b1, 1'b0, 1'b0));
        drain();
        check("u8 corr_cnt saturated", corr8, 2'd3);
        check("u8 uncorr_cnt idle", unc8, 2'd0);

        // Clear coinciding with a single-error transfer out.
        send8(12'h227, 1'b0, mk(8'hA5, 4'd12, 1'b1, 1'b0, 1'b0));
        n = 0;
        while (!ov8 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ov8) fail("u8 output never appeared for clear collision");
        clr8 = 1'b1;
        @(posedge clk);
        #1;
        clr8 = 1'b0;
        check("u8 clear wins over increment", corr8, 2'd0);
        drain();

        // Reset mid-burst discards in-flight words.
        for (int i = 0; i < 4; i++) send8(12'h227, 1'b0, mk(8'hA5, 4'd12, 1'b1, 1'b0, 1'b0));
        #1;
        rst8_n = 1'b0;
        #1;
        check("mid-reset u8 op_valid", ov8, 1'b0);
        check("mid-reset u8 op_ready", rdy8, 1'b1);
        check("mid-reset u8 op_data", data8, 8'h00);
        check("mid-reset u8 counters", {corr8, unc8}, 4'h0);
        q8.delete();
        @(negedge clk);
        #1;
        rst8_n = 1'b1;
        @(posedge clk);
        #1;
        c = enc(8, 4, 64'h3C, p);
        send8(c[11:0], p, mk(8'h3C, 4'd0, 1'b0, 1'b0, 1'b0));
        drain();
        check("u8 no stale output after reset", ov8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
